// File: rtl/bit_serializer_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bit_serializer_pkg : FSM encodings and width helper shared by the serial
//                      sequence-detector blocks.        Rev 1.0
// ---------------------------------------------------------------------------
package bit_serializer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } ser_state_e;

  // Ceiling log2, never below 1 so a counter always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bit_serializer : holding + shift register word serializer, tick-paced,
//                  gapless when the next word is already queued. Rev 1.0
// ---------------------------------------------------------------------------
module bit_serializer
  import bit_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1,
  parameter int IDLE_BIT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             busy,
  output logic             underrun
);

  localparam int               CNT_W    = clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
  localparam logic             IDLE_LVL = (IDLE_BIT != 0);

  ser_state_e       state_q;
  logic [WIDTH-1:0] hold_q;
  logic             hold_full_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CNT_W-1:0] bit_cnt_q;
  logic             ser_out_q;
  logic             ser_valid_q;
  logic             busy_q;
  logic             underrun_q;

  logic             w_accept;
  logic             w_last;
  logic             w_load;
  logic             w_step;
  logic             w_end;
  logic [WIDTH-1:0] w_src;
  logic             w_bit;
  logic [WIDTH-1:0] w_next_sh;
  logic             hold_full_d;
  logic             shifting_d;

  assign din_ready = ~hold_full_q & ~flush & ~rst;
  assign w_accept  = din_valid & din_ready;
  assign w_last    = (bit_cnt_q == LAST_CNT);

  // A load never coincides with an accept: loading needs holding full,
  // accepting needs it empty.
  assign w_load = tick & hold_full_q & ((state_q == ST_IDLE) | w_last);
  assign w_step = tick & (state_q == ST_SHIFT) & ~w_last;
  assign w_end  = tick & (state_q == ST_SHIFT) & w_last & ~hold_full_q;

  // Emitted bit and the remaining word come from the same source: the
  // holding word on a load, otherwise the shift register.
  assign w_src     = w_load ? hold_q : shreg_q;
  assign w_bit     = (MSB_FIRST != 0) ? w_src[WIDTH-1] : w_src[0];
  assign w_next_sh = (MSB_FIRST != 0) ? (w_src << 1) : (w_src >> 1);

  assign hold_full_d = w_accept | (hold_full_q & ~w_load);
  assign shifting_d  = w_load | ((state_q == ST_SHIFT) & ~w_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      ser_out_q   <= IDLE_LVL;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      hold_full_q <= 1'b0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      ser_out_q   <= IDLE_LVL;
      ser_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      hold_full_q <= hold_full_d;
      if (w_accept) hold_q <= din;
      busy_q     <= hold_full_d | shifting_d;
      underrun_q <= w_end;
      if (w_load) begin
        state_q     <= ST_SHIFT;
        shreg_q     <= w_next_sh;
        ser_out_q   <= w_bit;
        ser_valid_q <= 1'b1;
        bit_cnt_q   <= '0;
      end else if (w_step) begin
        shreg_q   <= w_next_sh;
        ser_out_q <= w_bit;
        bit_cnt_q <= bit_cnt_q + 1'b1;
      end else if (w_end) begin
        state_q     <= ST_IDLE;
        ser_out_q   <= IDLE_LVL;
        ser_valid_q <= 1'b0;
      end
    end
  end

  assign ser_out   = ser_out_q;
  assign ser_valid = ser_valid_q;
  assign busy      = busy_q;
  assign underrun  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bit_serializer : scoreboard bench, MSB-first/idle-0 and LSB-first/idle-1
//                     instances driven by shared stimulus.   Rev 1.0
// ---------------------------------------------------------------------------
module tb_bit_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       flush = 1'b0;
  logic       din_valid = 1'b0;
  logic [7:0] din = 8'h00;

  logic rdy_a, so_a, sv_a, busy_a, ur_a;
  logic rdy_b, so_b, sv_b, busy_b, ur_b;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_BIT(0)) u_dut_a (
    .clk(clk), .rst(rst), .tick(tick), .flush(flush), .din(din),
    .din_valid(din_valid), .din_ready(rdy_a), .ser_out(so_a),
    .ser_valid(sv_a), .busy(busy_a), .underrun(ur_a)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_BIT(1)) u_dut_b (
    .clk(clk), .rst(rst), .tick(tick), .flush(flush), .din(din),
    .din_valid(din_valid), .din_ready(rdy_b), .ser_out(so_b),
    .ser_valid(sv_b), .busy(busy_b), .underrun(ur_b)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Entry = {is_underrun, expected ser_out}
  logic [1:0] qa[$];
  logic [1:0] qb[$];

  int   tick_div = 1;
  int   tick_cnt = 0;
  logic tick_en  = 1'b0;

  always @(negedge clk) begin
    tick_cnt = tick_cnt + 1;
    tick = tick_en && ((tick_cnt % tick_div) == 0);
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: tick/flush/rst seen by the DUT at the last rising edge.
  logic lt = 1'b0, lf = 1'b0, lr = 1'b1;
  logic pv[2];
  logic po[2];
  always @(posedge clk) begin
    lt <= tick;
    lf <= flush;
    lr <= rst;
  end

  task automatic mon(input int idx, input logic v, input logic o, input logic u);
    logic [1:0] e;
    int n;
    n = (idx == 0) ? qa.size() : qb.size();
    if (rst) begin
    end else if (lt) begin
      if (v || u) begin
        if (n == 0) begin
          checks = checks + 1;
          errors = errors + 1;
          $display("FAIL unexpected_out dut%0d: got valid=%0b out=%0b underrun=%0b required none", idx, v, o, u);
        end else begin
          e = (idx == 0) ? qa.pop_front() : qb.pop_front();
          chk($sformatf("stream dut%0d", idx), int'({~v, o}), int'(e));
          if (e[1]) chk($sformatf("underrun_pulse dut%0d", idx), int'(u), 1);
        end
      end
    end else if (!lf && !lr) begin
      chk($sformatf("hold_between_ticks dut%0d", idx), int'({v, o, u}), int'({pv[idx], po[idx], 1'b0}));
    end
    pv[idx] = v;
    po[idx] = o;
  endtask

  always @(negedge clk) begin
    mon(0, sv_a, so_a, ur_a);
    mon(1, sv_b, so_b, ur_b);
  end

  task automatic push_word(input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      qa.push_back({1'b0, w[7-i]});
      qb.push_back({1'b0, w[i]});
    end
  endtask

  task automatic push_ur();
    qa.push_back(2'b10);
    qb.push_back(2'b11);
  endtask

  task automatic send(input logic [7:0] w);
    int n;
    n = 0;
    @(negedge clk);
    din = w;
    din_valid = 1'b1;
    while (!rdy_a && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", int'(n < 200), 1);
    @(posedge clk);
    push_word(w);
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((qa.size() != 0 || qb.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", qa.size() + qb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ser_out_a", int'(so_a), 0);
    chk("rst_ser_out_b", int'(so_b), 1);
    chk("rst_valid", int'({sv_a, sv_b}), 0);
    chk("rst_busy", int'({busy_a, busy_b}), 0);
    chk("rst_underrun", int'({ur_a, ur_b}), 0);
    chk("rst_ready", int'({rdy_a, rdy_b}), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", int'(rdy_a), 1);
    tick_en = 1'b1;

    // Single word, tick every cycle
    send(8'hB8);
    push_ur();
    drain();

    // Back-to-back words: no underrun between them
    send(8'hB8);
    chk("ready_low_holding_full", int'(rdy_a), 0);
    chk("busy_holding_full", int'(busy_a), 1);
    send(8'h5C);
    push_ur();
    drain();

    // LSB-first instance sees 1,0,1,1,1,0,0,0 for 8'h1D
    send(8'h1D);
    push_ur();
    drain();

    // Tick every 4th cycle: word spans 32 clocks from first bit to underrun
    tick_div = 4;
    send(8'hA5);
    push_ur();
    n = 0;
    while (!sv_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (!ur_a && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("word_span_clk", n, 32);
    drain();
    tick_div = 1;

    // Flush at bit 3 of 8'hFF with 8'h3C queued
    send(8'hFF);
    send(8'h3C);
    repeat (2) @(negedge clk);
    chk("pre_flush_bit3", int'({sv_a, so_a}), 3);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("flush_valid", int'({sv_a, sv_b}), 0);
    chk("flush_idle_level", int'({so_a, so_b}), 1);
    chk("flush_busy", int'({busy_a, busy_b}), 0);
    chk("flush_ready", int'(rdy_a), 1);
    chk("flush_underrun", int'({ur_a, ur_b}), 0);
    qa.delete();
    qb.delete();
    repeat (12) @(negedge clk);
    chk("flush_no_resume", int'({sv_a, busy_a, ur_a}), 0);

    // Async reset at bit 5, then a fresh word from bit 0
    send(8'hC3);
    repeat (6) @(negedge clk);
    chk("pre_rst_bit5", int'({sv_a, so_a}), 2);
    #1 rst = 1'b1;
    #1;
    chk("midrst_valid", int'({sv_a, sv_b}), 0);
    chk("midrst_idle_level", int'({so_a, so_b}), 1);
    chk("midrst_busy_ur", int'({busy_a, ur_a}), 0);
    chk("midrst_ready", int'(rdy_a), 0);
    qa.delete();
    qb.delete();
    @(negedge clk);
    rst = 1'b0;
    send(8'h96);
    push_ur();
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/bit_serializer.md
BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning word length in bits (legal 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1, meaning 1 = transmit bit WIDTH-1 first and 0 = transmit bit 0 first.
REQ-003 The block SHALL have parameter IDLE_BIT, default 0, meaning the ser_out level when no word is being sent.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port tick, input, 1 bit: bit-rate enable, one bit is emitted per clk cycle with tick=1.
REQ-007 The block SHALL have port flush, input, 1 bit: synchronous abort of the current and pending word.
REQ-008 The block SHALL have port din, input, WIDTH bits: parallel word.
REQ-009 The block SHALL have port din_valid, input, 1 bit: din is valid.
REQ-010 The block SHALL have port din_ready, output, 1 bit: the holding register can accept a word.
REQ-011 The block SHALL have port ser_out, output, 1 bit: serial bit stream to the downstream sequence detector.
REQ-012 The block SHALL have port ser_valid, output, 1 bit: ser_out carries a data bit.
REQ-013 The block SHALL have port busy, output, 1 bit: shift register or holding register is occupied.
REQ-014 The block SHALL have port underrun, output, 1 bit: one-cycle pulse when a word ends with no successor queued.

Function
REQ-015 Storage SHALL be a two-stage buffer: holding register plus shift register, with a bit counter of width clog2(WIDTH).
REQ-016 din_ready SHALL equal (holding empty) AND NOT flush, decoded from registered state only.
REQ-017 The holding register SHALL capture din on a clk edge where din_valid=1 and din_ready=1.
REQ-018 The FSM SHALL have two states, IDLE and SHIFT.
REQ-019 In IDLE, on tick with holding full, the block SHALL:
- move the holding word into the shift register;
- drive the first bit on ser_out with ser_valid=1;
- set bit_cnt=0;
- free the holding register;
- go to SHIFT.
REQ-020 In SHIFT, on tick with bit_cnt<WIDTH-1, the block SHALL output the next bit in MSB_FIRST order and increment bit_cnt.
REQ-021 In SHIFT, on tick with bit_cnt=WIDTH-1 and holding full, the block SHALL load the next word on the same edge, giving a gapless stream (first bit of the new word follows the last bit of the old word on the next tick).
REQ-022 In SHIFT, on tick with bit_cnt=WIDTH-1 and holding empty, the block SHALL set ser_out=IDLE_BIT and ser_valid=0, pulse underrun for exactly one clk, and go to IDLE.
REQ-023 Between ticks, ser_out, ser_valid and bit_cnt SHALL hold their values; latency from accept to first bit is the next tick edge after the accept edge.
REQ-024 A word accepted on the same edge as a tick SHALL NOT be transmitted on that tick.
REQ-025 Because din_ready is 0 while holding is full, a transfer and an accept into the holding register SHALL never coincide.
REQ-026 flush SHALL take priority over tick and accept: on the next edge, empty both registers, set ser_out=IDLE_BIT, ser_valid=0, underrun=0, and enter IDLE.
REQ-027 busy SHALL equal (state==SHIFT) OR holding full.
REQ-028 All outputs except din_ready SHALL be registered.

Reset
REQ-029 While rst=1, the block SHALL hold: state=IDLE, holding empty, shift register=0, bit_cnt=0, ser_out=IDLE_BIT, ser_valid=0, busy=0, underrun=0, din_ready=0.
REQ-030 After rst release, din_ready SHALL be 1.
REQ-031 rst asserted mid-word SHALL discard the word with no partial continuation after release.

Structure
REQ-032 The FSM state encodings and the clog2 width function SHALL reside in the shared package used by the sequence-detector blocks.
REQ-033 The block SHALL be a single module with no sub-modules; the shift/select logic is inline.

Verification
REQ-034 WIDTH=8, MSB_FIRST=1, tick every cycle; send 8'hB8 -> ser_out 1,0,1,1,1,0,0,0 with ser_valid=1 for 8 cycles, then underrun for one cycle, ser_out=0; downstream detector pulses on bit 5.
REQ-035 Send 8'hB8 then 8'h5C back-to-back -> 16 contiguous valid bits, no underrun between words, din_ready low while holding is full.
REQ-036 MSB_FIRST=0; send 8'h1D -> bit order 1,0,1,1,1,0,0,0.
REQ-037 tick every 4th cycle -> each bit is held for 4 clk and the word completes after 32 clk.
REQ-038 flush at bit 3 of 8'hFF with a word queued -> next cycle ser_valid=0, ser_out=IDLE_BIT, busy=0, din_ready=1, no underrun.
REQ-039 rst asserted at bit 5 -> all outputs at reset values immediately; after release the next word starts from bit 0.
